// File: rtl/spi_master4nano_if.sv
// Host-side request/response bundle for spi_master4nano.
//   req/rd/ram/addr/wdata : transaction request from the host controller
//   busy/done             : transaction status (done is a one-cycle pulse)
//   rdata/hdr_err         : result of the most recent read, held
// The master modport is the host controller. The slave modport is the SPI master
// block, which serves the host.
interface spi_master4nano_if;
  logic        req;
  logic        rd;
  logic        ram;
  logic [11:0] addr;
  logic [15:0] wdata;
  logic        busy;
  logic        done;
  logic [15:0] rdata;
  logic        hdr_err;

  modport master (output req, rd, ram, addr, wdata,
                  input  busy, done, rdata, hdr_err);
  modport slave  (input  req, rd, ram, addr, wdata,
                  output busy, done, rdata, hdr_err);
endinterface

// File: rtl/spi_master4nano.sv
// SPI master that programs and reads back the Nano CPU code ROM (8-bit) and
// data RAM (16-bit) through slave_spi4nano.
//   CLK, RST : system clock and synchronous active-high reset
//   host     : request/status bundle (spi_master4nano_if.slave)
//   CS, SCK  : slave select (active low) and serial clock (idles high)
//   MOSI     : serial data to the slave
//   MISO     : serial data from the slave
// A write sends one 32-bit frame, MSB first. A read sends a command frame and
// then an all-zero frame, and captures the slave's response during the second frame.
// HALF_DIV must be at least 4 and CS_GAP must be at least 8.
module spi_master4nano #(
  parameter int HALF_DIV = 4,
  parameter int CS_GAP   = 16
) (
  input  logic                CLK,
  input  logic                RST,
  spi_master4nano_if.slave    host,
  output logic                CS,
  output logic                SCK,
  output logic                MOSI,
  input  logic                MISO
);

  // One down-counter serves both the SCK half-periods and the CS gap.
  localparam int CNT_MAX = (HALF_DIV > CS_GAP) ? HALF_DIV : CS_GAP;
  localparam int DIV_W   = $clog2(CNT_MAX);
  localparam logic [DIV_W-1:0] HALF_RLD = DIV_W'(HALF_DIV - 1);
  localparam logic [DIV_W-1:0] GAP_RLD  = DIV_W'(CS_GAP - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, CS_SETUP, SCK_LO, SCK_HI, GAP, DONE
  } state_t;

  state_t           state;
  logic [31:0]      frame;
  logic [31:0]      shift;
  logic [31:0]      rx;
  logic [5:0]       bit_cnt;
  logic [DIV_W-1:0] div;
  logic             second;
  logic             rd_q;
  logic             ram_q;

  function automatic logic [31:0] build_frame(input logic rd, input logic ram,
                                              input logic [11:0] a,
                                              input logic [15:0] wd);
    logic [15:0] hi;
    logic [15:0] lo;
    if (ram) begin
      hi = {rd, 1'b1, 3'b000, a[10:0]};
      lo = wd;
    end else begin
      hi = {rd, 1'b0, 2'b00, a};
      lo = {8'h00, wd[7:0]};
    end
    if (rd) lo = 16'h0000;
    return {hi, lo};
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      CS           <= 1'b1;
      SCK          <= 1'b1;
      MOSI         <= 1'b0;
      host.busy    <= 1'b0;
      host.done    <= 1'b0;
      host.rdata   <= '0;
      host.hdr_err <= 1'b0;
      frame        <= '0;
      shift        <= '0;
      rx           <= '0;
      bit_cnt      <= '0;
      div          <= '0;
      second       <= 1'b0;
      rd_q         <= 1'b0;
      ram_q        <= 1'b0;
    end else begin
      host.done <= 1'b0;
      case (state)
        IDLE: begin
          if (host.req) begin
            rd_q      <= host.rd;
            ram_q     <= host.ram;
            frame     <= build_frame(host.rd, host.ram, host.addr, host.wdata);
            second    <= 1'b0;
            host.busy <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          shift   <= frame;
          bit_cnt <= '0;
          CS      <= 1'b0;
          SCK     <= 1'b1;
          div     <= HALF_RLD;
          state   <= CS_SETUP;
        end
        CS_SETUP: begin
          if (div == '0) begin
            SCK   <= 1'b0;
            MOSI  <= shift[31];
            shift <= {shift[30:0], 1'b0};
            div   <= HALF_RLD;
            state <= SCK_LO;
          end else begin
            div <= div - 1'b1;
          end
        end
        SCK_LO: begin
          if (div == '0) begin
            // Sample MISO at the end of the low phase, just before SCK rises.
            rx    <= {rx[30:0], MISO};
            SCK   <= 1'b1;
            div   <= HALF_RLD;
            state <= SCK_HI;
          end else begin
            div <= div - 1'b1;
          end
        end
        SCK_HI: begin
          if (div == '0) begin
            if (bit_cnt == 6'd31) begin
              CS    <= 1'b1;
              MOSI  <= 1'b0;
              div   <= GAP_RLD;
              state <= GAP;
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
              SCK     <= 1'b0;
              MOSI    <= shift[31];
              shift   <= {shift[30:0], 1'b0};
              div     <= HALF_RLD;
              state   <= SCK_LO;
            end
          end else begin
            div <= div - 1'b1;
          end
        end
        GAP: begin
          if (div == '0) begin
            if (rd_q && !second) begin
              // The response frame clocks out zeros while the slave replies.
              second  <= 1'b1;
              shift   <= '0;
              bit_cnt <= '0;
              CS      <= 1'b0;
              div     <= HALF_RLD;
              state   <= CS_SETUP;
            end else begin
              state <= DONE;
            end
          end else begin
            div <= div - 1'b1;
          end
        end
        DONE: begin
          host.done <= 1'b1;
          host.busy <= 1'b0;
          if (rd_q) begin
            host.hdr_err <= (rx[31:16] != frame[31:16]);
            host.rdata   <= ram_q ? rx[15:0] : {8'h00, rx[7:0]};
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
